shift_right_sequential: RTL and testbench

Multi-cycle right shifter covering logical (SRL) and arithmetic (SRA) right shifts. It mirrors the existing combinational left shifter, but resolves the shift amount one power-of-two stage per clock instead of through a 32-way mux. Operands enter and results leave through valid/ready handshakes, so the ALU/datapath can issue a shift and stall on the result. Any shift amount of 32 or more gives the fill value (zero or sign) in a single cycle.

---
 rtl/shift_right_sequential_if.sv | 24 ++
 rtl/shift_right_sequential.sv | 112 +++++++++++
 tb/tb_shift_right_sequential.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/shift_right_sequential_if.sv
// Operand/result handshake bundle for the sequential right shifter.
// The slave modport is the shifter; the master side issues operands and drains results.
interface shift_right_sequential_if #(
  parameter int N = 32
);
  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] in;
  logic [N-1:0] shamt;
  logic         arith;
  logic         o_valid;
  logic         o_ready;
  logic [N-1:0] out;

  modport master (
    output i_valid, in, shamt, arith, o_ready,
    input  i_ready, o_valid, out
  );

  modport slave (
    input  i_valid, in, shamt, arith, o_ready,
    output i_ready, o_valid, out
  );
endinterface

// File: rtl/shift_right_sequential.sv
// Multi-cycle logical/arithmetic right shifter: one power-of-two shift stage per clock,
// with a single-cycle path to the fill value when the shift amount is 32 or more.
module shift_right_sequential #(
  parameter int N = 32
) (
  input logic                      clk,
  input logic                      rst,
  shift_right_sequential_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t       r_state;
  logic [N-1:0] r_acc;
  logic [N-1:0] r_out;
  logic [4:0]   r_amt;
  logic [2:0]   r_stage;
  logic         r_mode;
  logic         r_sign;
  logic         r_o_valid;

  logic         w_ovf;
  logic         w_in_fill;
  logic         w_fill;
  logic [N-1:0] w_next_acc;

  // Shift right by 2^st, filling the vacated upper bits with the given fill bit.
  function automatic logic [N-1:0] shr_stage(input logic [N-1:0] a,
                                             input logic [2:0]   st,
                                             input logic         fill);
    logic [N-1:0] r;
    case (st)
      3'd0:    r = {{1{fill}},  a[N-1:1]};
      3'd1:    r = {{2{fill}},  a[N-1:2]};
      3'd2:    r = {{4{fill}},  a[N-1:4]};
      3'd3:    r = {{8{fill}},  a[N-1:8]};
      3'd4:    r = {{16{fill}}, a[N-1:16]};
      default: r = a;
    endcase
    return r;
  endfunction

  assign w_ovf      = |bus.shamt[N-1:5];
  assign w_in_fill  = bus.arith & bus.in[N-1];
  // Fill comes from the sign captured at accept, never from the shifted accumulator.
  assign w_fill     = r_mode & r_sign;
  assign w_next_acc = r_amt[r_stage] ? shr_stage(r_acc, r_stage, w_fill) : r_acc;

  assign bus.i_ready = (r_state == S_IDLE);
  assign bus.o_valid = r_o_valid;
  assign bus.out     = r_out;

  // Handshake FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_out     <= '0;
      r_amt     <= 5'd0;
      r_stage   <= 3'd0;
      r_mode    <= 1'b0;
      r_sign    <= 1'b0;
      r_o_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_valid) begin
            r_amt  <= bus.shamt[4:0];
            r_mode <= bus.arith;
            r_sign <= bus.in[N-1];
            if (w_ovf) begin
              r_acc     <= {N{w_in_fill}};
              r_out     <= {N{w_in_fill}};
              r_o_valid <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_acc   <= bus.in;
              r_stage <= 3'd0;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_acc <= w_next_acc;
          if (r_stage == 3'd4) begin
            r_stage   <= 3'd0;
            r_out     <= w_next_acc;
            r_o_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_stage <= r_stage + 3'd1;
          end
        end
        S_DONE: begin
          if (bus.o_ready) begin
            r_o_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_o_valid <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_right_sequential.sv
// Directed and random checks of the sequential right shifter against hand-computed
// values and a behavioural shift model.
module tb_shift_right_sequential;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  shift_right_sequential_if #(.N(32)) bus ();

  shift_right_sequential #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] s,
                                            input logic ar);
    logic signed [31:0] sa;
    sa = a;
    if (|s[31:5]) return (ar && a[31]) ? 32'hFFFF_FFFF : 32'h0000_0000;
    else if (ar)  return sa >>> s[4:0];
    else          return a >> s[4:0];
  endfunction

  // Wait (bounded) for o_valid; returns the number of edges after the accepting edge.
  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!bus.o_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // One full transaction: present, accept, scramble inputs, optional backpressure, handoff.
  task automatic do_op(input logic [31:0] a, input logic [31:0] s, input logic ar,
                       input logic [31:0] exp, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.in      = a;
    bus.shamt   = s;
    bus.arith   = ar;
    bus.o_ready = 1'b0;
    check("ready_idle", {31'd0, bus.i_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.in      = $urandom;
    bus.shamt   = $urandom_range(0, 31);
    bus.arith   = ~ar;
    wait_valid(lat);
    check("latency", lat, exp_lat);
    check("result", bus.out, exp);
    check("ready_busy", {31'd0, bus.i_ready}, 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, bus.o_valid}, 32'd1);
      check("bp_out", bus.out, exp);
      check("bp_ready", {31'd0, bus.i_ready}, 32'd0);
    end
    bus.o_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.o_ready = 1'b0;
    check("post_valid", {31'd0, bus.o_valid}, 32'd0);
    check("post_ready", {31'd0, bus.i_ready}, 32'd1);
  endtask

  logic [31:0] b2b_in  [4] = '{32'h8000_0000, 32'h1234_5678, 32'hF000_000F, 32'hDEAD_BEEF};
  logic [31:0] b2b_sh  [4] = '{32'd3,         32'd40,        32'd16,        32'd0};
  logic        b2b_ar  [4] = '{1'b1,          1'b0,          1'b1,          1'b0};
  logic [31:0] b2b_exp [4] = '{32'hF000_0000, 32'h0000_0000, 32'hFFFF_F000, 32'hDEAD_BEEF};
  int          b2b_lat [4] = '{5, 0, 5, 5};

  initial begin
    int          lat;
    logic [31:0] ra, rs;
    logic        rar;
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    bus.in      = 32'd0;
    bus.shamt   = 32'd0;
    bus.arith   = 1'b0;
    bus.o_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.i_ready}, 32'd1);
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_out", bus.out, 32'd0);
    rst = 1'b1;

    do_op(32'h8000_0000, 32'd31, 1'b0, 32'h0000_0001, 5, 0);
    do_op(32'h8000_0000, 32'd0,  1'b0, 32'h8000_0000, 5, 0);
    do_op(32'h8000_0000, 32'd4,  1'b1, 32'hF800_0000, 5, 3);
    do_op(32'h7FFF_FFF0, 32'd4,  1'b1, 32'h07FF_FFFF, 5, 0);
    do_op(32'hF000_0000, 32'd31, 1'b1, 32'hFFFF_FFFF, 5, 0);
    do_op(32'h8000_0001, 32'd31, 1'b1, 32'hFFFF_FFFF, 5, 0);
    // Overflowing amounts resolve straight out of the accepting edge.
    do_op(32'h8000_0001, 32'd32, 1'b1, 32'hFFFF_FFFF, 0, 0);
    do_op(32'h8000_0001, 32'd32, 1'b0, 32'h0000_0000, 0, 2);
    do_op(32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 0, 0);
    do_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 0, 0);

    // Back-to-back with i_valid held high; junk operands sit on the bus while busy.
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.o_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in    = b2b_in[k];
      bus.shamt = b2b_sh[k];
      bus.arith = b2b_ar[k];
      check("b2b_ready", {31'd0, bus.i_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus.in    = 32'hA5A5_A5A5;
      bus.shamt = 32'd1;
      bus.arith = 1'b1;
      wait_valid(lat);
      check("b2b_lat", lat, b2b_lat[k]);
      check("b2b_out", bus.out, b2b_exp[k]);
      @(posedge clk);
      @(negedge clk);
      check("b2b_idle", {31'd0, bus.i_ready}, 32'd1);
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b0;

    // Reset while the stage counter is at 2.
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.in      = 32'hFFFF_FFFF;
    bus.shamt   = 32'd7;
    bus.arith   = 1'b0;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("mid_rst_out", bus.out, 32'd0);
    check("mid_rst_ready", {31'd0, bus.i_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    do_op(32'hFFFF_FFFF, 32'd7, 1'b0, 32'h01FF_FFFF, 5, 0);

    for (int n = 0; n < 1000; n++) begin
      ra  = $urandom;
      rar = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 3) begin
        rs = $urandom;
        if (rs[31:5] == 27'd0) rs[5] = 1'b1;
      end else begin
        rs = $urandom_range(0, 31);
      end
      do_op(ra, rs, rar, ref_shift(ra, rs, rar), (|rs[31:5]) ? 0 : 5, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
